// File: rtl/risc_v_mem_wb.sv
// risc_v_mem_wb: back end of a 5-stage RISC-V pipeline.
// EX/MEM register, byte-lane data memory, MEM/WB register and writeback mux.
// Optional build macro MISALIGN_TRAP_EN adds MISALIGN_WB. With it, misaligned
// stores are dropped and misaligned loads do not write the register file.
// Without the macro, low address bits are truncated to the access size.
module risc_v_mem_wb #(
    parameter int DMEM_DEPTH = 1024,
    parameter int DMEM_AW    = $clog2(DMEM_DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_EX,
    input  logic        MemtoReg_EX,
    input  logic        MemRead_EX,
    input  logic        MemWrite_EX,
    input  logic        Branch_taken_EX,
    input  logic [31:0] PC_Branch_EX,
    input  logic [31:0] ALU_RESULT_EX,
    input  logic [31:0] STORE_DATA_EX,
    input  logic [2:0]  FUNCT3_EX,
    input  logic [4:0]  RD_EX,
    output logic        PCSrc,
    output logic [31:0] PC_Branch,
    output logic        RegWrite_MEM,
    output logic [4:0]  RD_MEM,
    output logic [31:0] ALU_RESULT_MEM,
    output logic        RegWrite_WB,
    output logic [4:0]  RD_WB,
    output logic [31:0] ALU_DATA_WB
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        MISALIGN_WB
`endif
);

    // Byte enables for a store of the given size at byte offset lo.
    function automatic logic [3:0] store_byte_en(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   store_byte_en = 4'b0001 << lo;
            2'b01:   store_byte_en = lo[1] ? 4'b1100 : 4'b0011;
            default: store_byte_en = 4'b1111;
        endcase
    endfunction

    // Replicate store data so that every enabled lane sees the right bytes.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   store_lanes = {4{d[7:0]}};
            2'b01:   store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    // Pick the addressed lane from a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] f3,
                                                 input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b100:  load_extract = {24'd0, b};
            3'b101:  load_extract = {16'd0, h};
            default: load_extract = w;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    // Halfword with odd address or word with nonzero low bits.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        is_misaligned = ((f3[1:0] == 2'b01) && lo[0]) ||
                        ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction
`endif

    // EX/MEM register
    logic        regwrite_mem_r, memtoreg_mem_r, memread_mem_r, memwrite_mem_r, branch_mem_r;
    logic [31:0] pc_branch_mem_r, alu_mem_r, store_mem_r;
    logic [2:0]  funct3_mem_r;
    logic [4:0]  rd_mem_r;

    // MEM/WB register and memory read word
    logic        regwrite_wb_r, memtoreg_wb_r, mis_wb_r;
    logic [2:0]  funct3_wb_r;
    logic [4:0]  rd_wb_r;
    logic [31:0] alu_wb_r, rdata_r;

    logic [31:0]        dmem_r [0:DMEM_DEPTH-1];
    logic [DMEM_AW-1:0] word_idx_s;
    logic [3:0]         byte_en_s;
    logic [31:0]        wdata_s;
    logic               mis_s;
    logic               store_en_s;
    logic [31:0]        load_data_s;

    // EX/MEM capture; a redirect in MEM turns the EX instruction into a bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            regwrite_mem_r  <= 1'b0;
            memtoreg_mem_r  <= 1'b0;
            memread_mem_r   <= 1'b0;
            memwrite_mem_r  <= 1'b0;
            branch_mem_r    <= 1'b0;
            pc_branch_mem_r <= 32'd0;
            alu_mem_r       <= 32'd0;
            store_mem_r     <= 32'd0;
            funct3_mem_r    <= 3'd0;
            rd_mem_r        <= 5'd0;
        end else begin
            regwrite_mem_r  <= RegWrite_EX     & ~branch_mem_r;
            memtoreg_mem_r  <= MemtoReg_EX     & ~branch_mem_r;
            memread_mem_r   <= MemRead_EX      & ~branch_mem_r;
            memwrite_mem_r  <= MemWrite_EX     & ~branch_mem_r;
            branch_mem_r    <= Branch_taken_EX & ~branch_mem_r;
            pc_branch_mem_r <= PC_Branch_EX;
            alu_mem_r       <= ALU_RESULT_EX;
            store_mem_r     <= STORE_DATA_EX;
            funct3_mem_r    <= FUNCT3_EX;
            rd_mem_r        <= RD_EX;
        end
    end

    assign word_idx_s = alu_mem_r[DMEM_AW+1:2];
    assign byte_en_s  = store_byte_en(funct3_mem_r, alu_mem_r[1:0]);
    assign wdata_s    = store_lanes(funct3_mem_r, store_mem_r);
`ifdef MISALIGN_TRAP_EN
    assign mis_s      = (memread_mem_r | memwrite_mem_r) & is_misaligned(funct3_mem_r, alu_mem_r[1:0]);
`else
    assign mis_s      = 1'b0;
`endif
    assign store_en_s = memwrite_mem_r & ~mis_s & reset;

    // Data memory: byte-lane store and synchronous read; contents are never reset.
    always_ff @(posedge clk) begin
        if (store_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_s[b]) begin
                    dmem_r[word_idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
                end
            end
        end
        if (memread_mem_r) begin
            rdata_r <= dmem_r[word_idx_s];
        end
    end

    // MEM/WB capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            regwrite_wb_r <= 1'b0;
            memtoreg_wb_r <= 1'b0;
            mis_wb_r      <= 1'b0;
            funct3_wb_r   <= 3'd0;
            rd_wb_r       <= 5'd0;
            alu_wb_r      <= 32'd0;
        end else begin
            regwrite_wb_r <= regwrite_mem_r;
            memtoreg_wb_r <= memtoreg_mem_r;
            mis_wb_r      <= mis_s & memread_mem_r;
            funct3_wb_r   <= funct3_mem_r;
            rd_wb_r       <= rd_mem_r;
            alu_wb_r      <= alu_mem_r;
        end
    end

    // Writeback mux between extracted load data and the ALU result.
    always_comb begin
        load_data_s = load_extract(rdata_r, funct3_wb_r, alu_wb_r[1:0]);
        if (memtoreg_wb_r) begin
            ALU_DATA_WB = load_data_s;
        end else begin
            ALU_DATA_WB = alu_wb_r;
        end
    end

    assign PCSrc          = branch_mem_r;
    assign PC_Branch      = pc_branch_mem_r;
    assign RegWrite_MEM   = regwrite_mem_r;
    assign RD_MEM         = rd_mem_r;
    assign ALU_RESULT_MEM = alu_mem_r;
    assign RD_WB          = rd_wb_r;
    assign RegWrite_WB    = regwrite_wb_r & (rd_wb_r != 5'd0) & ~mis_wb_r;
`ifdef MISALIGN_TRAP_EN
    assign MISALIGN_WB    = mis_wb_r;
`endif

endmodule

// File: tb/tb_risc_v_mem_wb.sv
// Self-checking bench for risc_v_mem_wb: table of instructions with a
// scoreboard queue of expected writeback results, plus hand sequences for
// reset, branch squash and reset during a store.
module tb_risc_v_mem_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_taken_EX;
    logic [31:0] PC_Branch_EX, ALU_RESULT_EX, STORE_DATA_EX;
    logic [2:0]  FUNCT3_EX;
    logic [4:0]  RD_EX;
    logic        PCSrc, RegWrite_MEM, RegWrite_WB;
    logic [31:0] PC_Branch, ALU_RESULT_MEM, ALU_DATA_WB;
    logic [4:0]  RD_MEM, RD_WB;
`ifdef MISALIGN_TRAP_EN
    logic        MISALIGN_WB;
`endif

    int checks   = 0;
    int failures = 0;

    risc_v_mem_wb dut (
        .clk(clk), .reset(reset),
        .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX), .MemRead_EX(MemRead_EX),
        .MemWrite_EX(MemWrite_EX), .Branch_taken_EX(Branch_taken_EX),
        .PC_Branch_EX(PC_Branch_EX), .ALU_RESULT_EX(ALU_RESULT_EX),
        .STORE_DATA_EX(STORE_DATA_EX), .FUNCT3_EX(FUNCT3_EX), .RD_EX(RD_EX),
        .PCSrc(PCSrc), .PC_Branch(PC_Branch), .RegWrite_MEM(RegWrite_MEM),
        .RD_MEM(RD_MEM), .ALU_RESULT_MEM(ALU_RESULT_MEM), .RegWrite_WB(RegWrite_WB),
        .RD_WB(RD_WB), .ALU_DATA_WB(ALU_DATA_WB)
`ifdef MISALIGN_TRAP_EN
        , .MISALIGN_WB(MISALIGN_WB)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw, m2r, mr, mw, br;
        logic [31:0] pcb, alu, sd;
        logic [2:0]  f3;
        logic [4:0]  rd;
    } ex_t;

    typedef struct {
        logic        chk, we, mis;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    typedef struct {
        ex_t x;
        wb_t e;
    } vec_t;

    wb_t   exp_q [$];
    string tag_q [$];
    vec_t  tbl   [16];

    function automatic ex_t mk_nop();
        ex_t x;
        x.rw = 1'b0; x.m2r = 1'b0; x.mr = 1'b0; x.mw = 1'b0; x.br = 1'b0;
        x.pcb = 32'd0; x.alu = 32'd0; x.sd = 32'd0; x.f3 = 3'd0; x.rd = 5'd0;
        return x;
    endfunction

    function automatic ex_t mk_alu(input logic [4:0] rd, input logic [31:0] v);
        ex_t x = mk_nop();
        x.rw = 1'b1; x.rd = rd; x.alu = v;
        return x;
    endfunction

    function automatic ex_t mk_ld(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
        ex_t x = mk_nop();
        x.rw = 1'b1; x.m2r = 1'b1; x.mr = 1'b1; x.f3 = f3; x.alu = a; x.rd = rd;
        return x;
    endfunction

    function automatic ex_t mk_st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        ex_t x = mk_nop();
        x.mw = 1'b1; x.f3 = f3; x.alu = a; x.sd = d;
        return x;
    endfunction

    function automatic ex_t mk_br(input logic [31:0] t);
        ex_t x = mk_nop();
        x.br = 1'b1; x.pcb = t;
        return x;
    endfunction

    function automatic wb_t ew(input logic we, input logic [4:0] rd, input logic [31:0] d);
        wb_t e;
        e.chk = 1'b1; e.we = we; e.mis = 1'b0; e.rd = rd; e.data = d;
        return e;
    endfunction

    function automatic wb_t en();
        wb_t e;
        e.chk = 1'b0; e.we = 1'b0; e.mis = 1'b0; e.rd = 5'd0; e.data = 32'd0;
        return e;
    endfunction

    function automatic wb_t emis();
        wb_t e = en();
        e.mis = 1'b1;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input ex_t x);
        RegWrite_EX = x.rw; MemtoReg_EX = x.m2r; MemRead_EX = x.mr; MemWrite_EX = x.mw;
        Branch_taken_EX = x.br; PC_Branch_EX = x.pcb; ALU_RESULT_EX = x.alu;
        STORE_DATA_EX = x.sd; FUNCT3_EX = x.f3; RD_EX = x.rd;
    endtask

    // Drive one instruction for one cycle; compare the one that reaches WB.
    task automatic issue(input ex_t x, input wb_t e, input string tag);
        wb_t   p;
        string t;
        drive(x);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (exp_q.size() > 1) begin
            p = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, "_we"}, {31'd0, RegWrite_WB}, {31'd0, p.we});
            if (p.chk) begin
                check({t, "_rd"}, {27'd0, RD_WB}, {27'd0, p.rd});
                check({t, "_data"}, ALU_DATA_WB, p.data);
            end
`ifdef MISALIGN_TRAP_EN
            check({t, "_mis"}, {31'd0, MISALIGN_WB}, {31'd0, p.mis});
`endif
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pcsrc"}, {31'd0, PCSrc}, 32'd0);
        check({tag, "_pcb"}, PC_Branch, 32'd0);
        check({tag, "_rw_mem"}, {31'd0, RegWrite_MEM}, 32'd0);
        check({tag, "_rd_mem"}, {27'd0, RD_MEM}, 32'd0);
        check({tag, "_alu_mem"}, ALU_RESULT_MEM, 32'd0);
        check({tag, "_rw_wb"}, {31'd0, RegWrite_WB}, 32'd0);
        check({tag, "_rd_wb"}, {27'd0, RD_WB}, 32'd0);
        check({tag, "_data_wb"}, ALU_DATA_WB, 32'd0);
    endtask

    initial begin
        // Table: memory word at 0x40 evolves DEADBEEF -> DEAD7FEF -> (SH) DEADCAFE
        tbl[0]  = '{mk_st(3'b010, 32'h40, 32'hDEADBEEF), en()};
        tbl[1]  = '{mk_ld(3'b010, 32'h40, 5'd1), ew(1'b1, 5'd1, 32'hDEADBEEF)};
        tbl[2]  = '{mk_st(3'b000, 32'h41, 32'h1234567F), en()};
        tbl[3]  = '{mk_ld(3'b010, 32'h40, 5'd2), ew(1'b1, 5'd2, 32'hDEAD7FEF)};
        tbl[4]  = '{mk_ld(3'b000, 32'h43, 5'd3), ew(1'b1, 5'd3, 32'hFFFFFFDE)};
        tbl[5]  = '{mk_ld(3'b100, 32'h43, 5'd4), ew(1'b1, 5'd4, 32'h000000DE)};
        tbl[6]  = '{mk_ld(3'b001, 32'h42, 5'd5), ew(1'b1, 5'd5, 32'hFFFFDEAD)};
        tbl[7]  = '{mk_ld(3'b101, 32'h42, 5'd6), ew(1'b1, 5'd6, 32'h0000DEAD)};
`ifdef MISALIGN_TRAP_EN
        tbl[8]  = '{mk_ld(3'b010, 32'h42, 5'd7), emis()};
`else
        tbl[8]  = '{mk_ld(3'b010, 32'h42, 5'd7), ew(1'b1, 5'd7, 32'hDEAD7FEF)};
`endif
        tbl[9]  = '{mk_st(3'b001, 32'h41, 32'hAAAACAFE), en()};
`ifdef MISALIGN_TRAP_EN
        tbl[10] = '{mk_ld(3'b010, 32'h40, 5'd8), ew(1'b1, 5'd8, 32'hDEAD7FEF)};
`else
        tbl[10] = '{mk_ld(3'b010, 32'h40, 5'd8), ew(1'b1, 5'd8, 32'hDEADCAFE)};
`endif
        tbl[11] = '{mk_alu(5'd0, 32'h999), ew(1'b0, 5'd0, 32'h999)};
        tbl[12] = '{mk_st(3'b010, 32'h1000, 32'h11223344), en()};
        tbl[13] = '{mk_ld(3'b010, 32'h0, 5'd9), ew(1'b1, 5'd9, 32'h11223344)};
        tbl[14] = '{mk_st(3'b010, 32'h80, 32'h12345678), en()};
        tbl[15] = '{mk_alu(5'd31, 32'hA5A5A5A5), ew(1'b1, 5'd31, 32'hA5A5A5A5)};

        // Reset for two cycles with busy inputs.
        reset = 1'b0;
        drive(mk_br(32'h200));
        RegWrite_EX = 1'b1; RD_EX = 5'd7; ALU_RESULT_EX = 32'hFFFF;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_all_zero("reset");
        reset = 1'b1;

        // First ALU instruction: visible in MEM after one edge, WB after two.
        issue(mk_alu(5'd5, 32'h1234), ew(1'b1, 5'd5, 32'h1234), "alu_first");
        check("fwd_rw_mem", {31'd0, RegWrite_MEM}, 32'd1);
        check("fwd_rd_mem", {27'd0, RD_MEM}, 32'd5);
        check("fwd_alu_mem", ALU_RESULT_MEM, 32'h1234);
        check("alu_first_not_early", {31'd0, RegWrite_WB}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            issue(tbl[i].x, tbl[i].e, $sformatf("vec%0d", i));
        end

        // Taken branch squashes the store behind it; memory at 0x80 keeps 0x12345678.
        issue(mk_br(32'h100), en(), "branch");
        check("branch_pcsrc", {31'd0, PCSrc}, 32'd1);
        check("branch_target", PC_Branch, 32'h100);
        issue(mk_st(3'b010, 32'h80, 32'h55555555), en(), "squashed_st");
        check("branch_pcsrc_one_cycle", {31'd0, PCSrc}, 32'd0);
        issue(mk_ld(3'b010, 32'h80, 5'd10), ew(1'b1, 5'd10, 32'h12345678), "after_squash");
        issue(mk_nop(), en(), "drain0");
        issue(mk_nop(), en(), "drain1");

        // Reset arriving while a store sits in MEM suppresses that store.
        issue(mk_st(3'b010, 32'h60, 32'h0BADF00D), en(), "st60");
        issue(mk_nop(), en(), "drain2");
        issue(mk_nop(), en(), "drain3");
        exp_q.delete();
        tag_q.delete();
        drive(mk_st(3'b010, 32'h60, 32'hFFFFFFFF));
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(mk_nop());
        @(posedge clk);
        #1;
        check_all_zero("midreset");
        reset = 1'b1;
        issue(mk_ld(3'b010, 32'h60, 5'd12), ew(1'b1, 5'd12, 32'h0BADF00D), "ld60");
        issue(mk_nop(), en(), "drain4");
        issue(mk_nop(), en(), "drain5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
